// File: rtl/lsu_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lsu_bus_master
// Purpose  : MEM-stage load/store bus master. Issues one valid/ready request
//            per aligned load/store, waits for the response or a timeout,
//            stalls the pipeline meanwhile and returns extended load data.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_bus_master #(
  parameter int ADDR_W         = 32,
  // Cycles allowed in WAIT_RSP before an error completion; legal range 1..255.
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read_mem,
  input  logic              mem_write_mem,
  input  logic [2:0]        fun3_mem,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic [31:0]       wdata_mem,
  output logic              stall_pipl,
  output logic [31:0]       rdata_mem,
  output logic              misaligned_mem,
  output logic              bus_error_mem,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_we,
  output logic [31:0]       req_wdata,
  output logic [3:0]        req_wstrb,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic [2:0]        fun3_q;
  logic [1:0]        off_q;
  logic              req_valid_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              req_we_q;
  logic [31:0]       req_wdata_q;
  logic [3:0]        req_wstrb_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              rw;
  logic              access;
  logic [ADDR_W-1:0] addr_d;
  logic [3:0]        wstrb_d;
  logic [31:0]       wdata_d;
  logic [7:0]        lbyte;
  logic [15:0]       lhalf;
  logic [31:0]       ld_d;

  assign rw             = mem_read_mem | mem_write_mem;
  assign misaligned_mem = rw & (((fun3_mem[1:0] == 2'b01) & addr_mem[0]) |
                                ((fun3_mem[1:0] == 2'b10) & (addr_mem[1:0] != 2'b00)));
  assign access         = rw & ~misaligned_mem;
  // Released for exactly the DONE cycle so the pipeline can advance.
  assign stall_pipl     = access & (state_q != DONE);
  assign cnt_d          = cnt_q + 8'd1;
  assign addr_d         = {addr_mem[ADDR_W-1:2], 2'b00};

  assign req_valid      = req_valid_q;
  assign req_addr       = req_addr_q;
  assign req_we         = req_we_q;
  assign req_wdata      = req_wdata_q;
  assign req_wstrb      = req_wstrb_q;
  assign rdata_mem      = rdata_q;
  assign bus_error_mem  = err_q;

  // Store lane steering: byte/halfword replicated across lanes, strobes shifted.
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = 32'h0;
    if (mem_write_mem) begin
      case (fun3_mem[1:0])
        2'b00: begin
          wstrb_d = 4'b0001 << addr_mem[1:0];
          wdata_d = {4{wdata_mem[7:0]}};
        end
        2'b01: begin
          wstrb_d = 4'b0011 << addr_mem[1:0];
          wdata_d = {2{wdata_mem[15:0]}};
        end
        default: begin
          wstrb_d = 4'b1111;
          wdata_d = wdata_mem;
        end
      endcase
    end
  end

  // Load extraction from the response word using the latched offset/funct3.
  always_comb begin
    lbyte = 8'(rsp_rdata >> {off_q, 3'b000});
    lhalf = off_q[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    case (fun3_q)
      3'b000:  ld_d = {{24{lbyte[7]}}, lbyte};
      3'b100:  ld_d = {24'h0, lbyte};
      3'b001:  ld_d = {{16{lhalf[15]}}, lhalf};
      3'b101:  ld_d = {16'h0, lhalf};
      default: ld_d = rsp_rdata;
    endcase
    if (req_we_q) begin
      ld_d = 32'h0;
    end
  end

  // Transaction FSM with registered bus and completion outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      fun3_q      <= 3'd0;
      off_q       <= 2'd0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= 32'h0;
      req_wstrb_q <= 4'b0000;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            req_addr_q  <= addr_d;
            req_we_q    <= mem_write_mem;
            req_wdata_q <= wdata_d;
            req_wstrb_q <= wstrb_d;
            fun3_q      <= fun3_mem;
            off_q       <= addr_mem[1:0];
            req_valid_q <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid_q <= 1'b0;
            cnt_q       <= 8'd0;
            state_q     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A response on the timeout cycle still completes normally.
          if (rsp_valid) begin
            rdata_q <= ld_d;
            err_q   <= 1'b0;
            state_q <= DONE;
          end else if (cnt_d == TMO) begin
            cnt_q   <= cnt_d;
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lsu_bus_master
// Purpose  : Directed bench for lsu_bus_master with request/response
//            scoreboards checked by a negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_bus_master;

  localparam int TMO = 12;

  logic        clk;
  logic        reset_n;
  logic        mem_read_mem;
  logic        mem_write_mem;
  logic [2:0]  fun3_mem;
  logic [31:0] addr_mem;
  logic [31:0] wdata_mem;
  logic        stall_pipl;
  logic [31:0] rdata_mem;
  logic        misaligned_mem;
  logic        bus_error_mem;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  lsu_bus_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .fun3_mem(fun3_mem), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .stall_pipl(stall_pipl), .rdata_mem(rdata_mem),
    .misaligned_mem(misaligned_mem), .bus_error_mem(bus_error_mem),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  req_t mon_req;
  rsp_t mon_rsp;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   in_txn  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: request handshakes and completions are popped against the queues.
  always @(negedge clk) begin
    if (reset_n && req_valid && req_ready) begin
      if (exp_req.size() == 0) begin
        chk("req_unexpected", 32'd1, 32'd0);
      end else begin
        mon_req = exp_req.pop_front();
        chk("req_addr",  req_addr,  mon_req.addr);
        chk("req_we",    {31'd0, req_we}, {31'd0, mon_req.we});
        chk("req_wdata", req_wdata, mon_req.wdata);
        chk("req_wstrb", {28'd0, req_wstrb}, {28'd0, mon_req.wstrb});
      end
    end
    if (in_txn && !stall_pipl) begin
      if (exp_rsp.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_rsp = exp_rsp.pop_front();
        chk("rdata_mem",     rdata_mem, mon_rsp.rdata);
        chk("bus_error_mem", {31'd0, bus_error_mem}, {31'd0, mon_rsp.err});
      end
    end
  end

  task automatic clear_inputs();
    mem_read_mem  = 1'b0;
    mem_write_mem = 1'b0;
    fun3_mem      = 3'd0;
    addr_mem      = 32'h0;
    wdata_mem     = 32'h0;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rdata     = 32'h0;
  endtask

  // One access: rdelay = REQ cycles with ready low, rspdelay = WAIT cycles
  // before rsp_valid (-1 = never), noise = rsp_valid toggled outside WAIT.
  task automatic run_access(
    input string nm, input bit rd, input bit wr, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wdat,
    input int rdelay, input int rspdelay, input logic [31:0] rdat, input bit noise,
    input logic [31:0] e_addr, input bit e_we, input logic [31:0] e_wdata,
    input logic [3:0] e_wstrb, input logic [31:0] e_rdata, input bit e_err,
    input int e_stall);
    int rv_seen;
    int wcnt;
    int stall_cnt;
    bit hs;
    bit hs_now;
    bit rv_s;
    bit done;
    bit stable;
    rv_seen = 0; wcnt = 0; stall_cnt = 0; hs = 0; done = 0; stable = 1;
    exp_req.push_back('{addr: e_addr, we: e_we, wdata: e_wdata, wstrb: e_wstrb});
    exp_rsp.push_back('{rdata: e_rdata, err: e_err});
    mem_read_mem  = rd;
    mem_write_mem = wr;
    fun3_mem      = f3;
    addr_mem      = addr;
    wdata_mem     = wdat;
    in_txn        = 1'b1;
    for (int k = 0; k < 600 && !done; k++) begin
      req_ready = req_valid && (rv_seen >= rdelay);
      rsp_valid = hs ? ((rspdelay >= 0) && (wcnt == rspdelay)) : noise;
      rsp_rdata = hs ? rdat : 32'hBADBAD00;
      @(negedge clk);
      if (stall_pipl) stall_cnt++;
      else done = 1;
      rv_s   = req_valid;
      hs_now = req_valid && req_ready;
      if (req_valid && !req_ready &&
          !(req_addr == e_addr && req_we == e_we && req_wdata == e_wdata && req_wstrb == e_wstrb))
        stable = 0;
      @(posedge clk); #1;
      if (hs) wcnt++;
      if (hs_now) hs = 1;
      if (rv_s && !hs_now) rv_seen++;
    end
    chk({nm, "_completed"}, {31'd0, done}, 32'd1);
    chk({nm, "_stall_cycles"}, stall_cnt, e_stall);
    if (rdelay > 0) chk({nm, "_req_stable"}, {31'd0, stable}, 32'd1);
    in_txn = 1'b0;
    clear_inputs();
  endtask

  task automatic run_misaligned(input string nm, input bit rd, input bit wr,
                                input logic [2:0] f3, input logic [31:0] addr);
    int rv;
    rv = 0;
    mem_read_mem  = rd;
    mem_write_mem = wr;
    fun3_mem      = f3;
    addr_mem      = addr;
    wdata_mem     = 32'h11223344;
    @(negedge clk);
    chk({nm, "_misaligned"}, {31'd0, misaligned_mem}, 32'd1);
    chk({nm, "_stall"}, {31'd0, stall_pipl}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (req_valid) rv++;
    end
    chk({nm, "_no_req"}, rv, 0);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_req_addr",  req_addr, 32'h0);
    chk("rst_req_wstrb", {28'd0, req_wstrb}, 32'd0);
    chk("rst_rdata",     rdata_mem, 32'h0);
    chk("rst_stall",     {31'd0, stall_pipl}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Stray responses while idle must not start or complete anything.
    rsp_valid = 1'b1;
    rsp_rdata = 32'h12345678;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("idle_stray_req_valid", {31'd0, req_valid}, 32'd0);
    chk("idle_stray_rdata",     rdata_mem, 32'h0);
    @(posedge clk); #1;
    clear_inputs();

    //          name    rd wr f3      addr          wdata         rdl rspd rdata         nz  e_addr        we e_wdata       e_wstrb  e_rdata       err stall
    run_access("LW",    1, 0, 3'b010, 32'h104,      32'h0,        0,  0,   32'hDEADBEEF, 0,  32'h104,      0, 32'h0,        4'b0000, 32'hDEADBEEF, 0,  3);
    run_access("LB",    1, 0, 3'b000, 32'h103,      32'h0,        0,  0,   32'h80FF0000, 0,  32'h100,      0, 32'h0,        4'b0000, 32'hFFFFFF80, 0,  3);
    run_access("LBU",   1, 0, 3'b100, 32'h103,      32'h0,        0,  0,   32'h80FF0000, 0,  32'h100,      0, 32'h0,        4'b0000, 32'h00000080, 0,  3);
    run_access("LH",    1, 0, 3'b001, 32'h102,      32'h0,        0,  0,   32'h80FF0000, 0,  32'h100,      0, 32'h0,        4'b0000, 32'hFFFF80FF, 0,  3);
    run_access("LHU",   1, 0, 3'b101, 32'h102,      32'h0,        0,  0,   32'h80FF0000, 0,  32'h100,      0, 32'h0,        4'b0000, 32'h000080FF, 0,  3);
    run_access("LB2",   1, 0, 3'b000, 32'h102,      32'h0,        0,  0,   32'h80FF0000, 0,  32'h100,      0, 32'h0,        4'b0000, 32'hFFFFFFFF, 0,  3);
    run_access("LX011", 1, 0, 3'b011, 32'h108,      32'h0,        0,  0,   32'h12345678, 0,  32'h108,      0, 32'h0,        4'b0000, 32'h12345678, 0,  3);
    run_access("SB",    0, 1, 3'b000, 32'h202,      32'h000000A5, 0,  0,   32'h77777777, 0,  32'h200,      1, 32'hA5A5A5A5, 4'b0100, 32'h0,        0,  3);
    run_access("SB3",   0, 1, 3'b000, 32'h003,      32'hFFFF005A, 0,  0,   32'h77777777, 0,  32'h000,      1, 32'h5A5A5A5A, 4'b1000, 32'h0,        0,  3);
    run_access("SH",    0, 1, 3'b001, 32'h202,      32'h1234BEEF, 2,  3,   32'h77777777, 1,  32'h200,      1, 32'hBEEFBEEF, 4'b1100, 32'h0,        0,  8);
    run_access("SW",    0, 1, 3'b010, 32'h300,      32'hCAFEF00D, 0,  0,   32'h0,        0,  32'h300,      1, 32'hCAFEF00D, 4'b1111, 32'h0,        0,  3);
    run_access("RDWR",  1, 1, 3'b010, 32'h204,      32'h01020304, 0,  0,   32'h99999999, 0,  32'h204,      1, 32'h01020304, 4'b1111, 32'h0,        0,  3);
    run_access("TMO",   1, 0, 3'b010, 32'h400,      32'h0,        5, -1,   32'h0,        1,  32'h400,      0, 32'h0,        4'b0000, 32'h0,        1,  1 + 6 + TMO);
    chk("tmo_err_held", {31'd0, bus_error_mem}, 32'd1);
    run_access("RSPWIN",1, 0, 3'b010, 32'h404,      32'h0,        0,  TMO-1, 32'h0BADF00D, 0, 32'h404,    0, 32'h0,        4'b0000, 32'h0BADF00D, 0,  2 + TMO);

    run_misaligned("LW101", 1, 0, 3'b010, 32'h101);
    run_misaligned("LH103", 1, 0, 3'b001, 32'h103);
    run_misaligned("SW202", 0, 1, 3'b010, 32'h202);

    // Reset while waiting for a response.
    exp_req.push_back('{addr: 32'h1F0, we: 1'b0, wdata: 32'h0, wstrb: 4'b0000});
    mem_read_mem = 1'b1;
    fun3_mem     = 3'b010;
    addr_mem     = 32'h1F0;
    @(posedge clk); #1;
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_stall", {31'd0, stall_pipl}, 32'd1);
    reset_n = 1'b0;
    clear_inputs();
    #1;
    chk("arst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("arst_req_addr",  req_addr, 32'h0);
    chk("arst_req_we",    {31'd0, req_we}, 32'd0);
    chk("arst_req_wdata", req_wdata, 32'h0);
    chk("arst_rdata",     rdata_mem, 32'h0);
    chk("arst_bus_error", {31'd0, bus_error_mem}, 32'd0);
    chk("arst_stall",     {31'd0, stall_pipl}, 32'd0);
    @(posedge clk); #1;
    reset_n   = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h55AA55AA;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("post_rst_stray_req_valid", {31'd0, req_valid}, 32'd0);
    chk("post_rst_stray_rdata",     rdata_mem, 32'h0);
    @(posedge clk); #1;
    clear_inputs();

    run_access("LW_AFTER_RST", 1, 0, 3'b010, 32'h500, 32'h0, 0, 0, 32'h600DCAFE, 0,
               32'h500, 0, 32'h0, 4'b0000, 32'h600DCAFE, 0, 3);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rdata_held", rdata_mem, 32'h600DCAFE);

    chk("req_queue_drained", exp_req.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
